mux21_rr_arbiter: RTL

- Round-robin arbiter and sequencer that shares one 2:1 mux datapath between two requesters.
- Owns the select line and registers the muxed data beat together with a valid flag.
- Caps the length of any one grant with a hold limit, so a requester that keeps its request up cannot starve the other.
- Sits in front of a downstream consumer that samples dout when dout_valid is high.

---
 rtl/mux21_rr_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/mux21_rr_arbiter.sv
`default_nettype none
// mux21_rr_arbiter: round-robin arbiter driving a shared 2:1 data mux with a
// registered output beat and a per-grant hold limit.
module mux21_rr_arbiter #(
   parameter int DW       = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req0,
   input  logic          req1,
   input  logic [DW-1:0] din0,
   input  logic [DW-1:0] din1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          sel,
   output logic [DW-1:0] dout,
   output logic          dout_valid
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_G0   = 2'd1;
   localparam logic [1:0] S_G1   = 2'd2;

   localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

   logic [1:0]    state_q, state_d;
   logic          last_q, last_d;
   logic [3:0]    hold_q, hold_d;
   logic [DW-1:0] dout_q, dout_d;
   logic          dv_q, dv_d;

   logic          own_id;
   logic          own_req;
   logic          oth_req;
   logic [DW-1:0] own_din;
   logic [1:0]    oth_state;

   assign own_id    = (state_q == S_G1);
   assign own_req   = own_id ? req1 : req0;
   assign oth_req   = own_id ? req0 : req1;
   assign own_din   = own_id ? din1 : din0;
   assign oth_state = own_id ? S_G0 : S_G1;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      hold_d  = hold_q;
      dout_d  = dout_q;
      dv_d    = 1'b0;
      case (state_q)
         S_G0, S_G1: begin
            if (!own_req) begin
               state_d = oth_req ? oth_state : S_IDLE;
               last_d  = own_id;
               hold_d  = 4'd0;
            end else begin
               dout_d = own_din;
               dv_d   = 1'b1;
               if (oth_req && (hold_q == HOLD_LAST)) begin
                  state_d = oth_state;
                  last_d  = own_id;
                  hold_d  = 4'd0;
               end else if (hold_q != HOLD_LAST) begin
                  // Saturates while the other port is quiet, so a late request
                  // from it forces a switch after exactly one more beat.
                  hold_d = hold_q + 4'd1;
               end
            end
         end
         default: begin
            if (req0 && req1) begin
               state_d = last_q ? S_G0 : S_G1;
            end else if (req0) begin
               state_d = S_G0;
            end else if (req1) begin
               state_d = S_G1;
            end else begin
               state_d = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         last_q  <= 1'b1;
         hold_q  <= 4'd0;
         dout_q  <= '0;
         dv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
         dout_q  <= dout_d;
         dv_q    <= dv_d;
      end
   end

   assign gnt0       = (state_q == S_G0);
   assign gnt1       = (state_q == S_G1);
   assign sel        = gnt1;
   assign dout       = dout_q;
   assign dout_valid = dv_q;

endmodule
`default_nettype wire
